// File: rtl/prefetch_queue_pkg.sv
// rtl/prefetch_queue_pkg.sv - shared types for the instruction prefetch queue
//
// Purpose: fetch FSM state encoding, the decoder window width shared with the
// pre-decoder, reset values and the segment:offset address helper.
// Ports: none (package).

package prefetch_queue_pkg;

   typedef enum logic {
      PF_IDLE = 1'b0,
      PF_REQ  = 1'b1
   } prefetch_state_e;

   // Bytes presented to the pre-decoder: opcode + modrm + disp16 + imm16.
   localparam int PREFETCH_WINDOW = 6;

   // Fetch restarts at FFFF:0000 so the first request targets 20'hFFFF0.
   localparam logic [15:0] PF_RESET_PS = 16'hFFFF;
   localparam logic [15:0] PF_RESET_PC = 16'h0000;

   // Word-aligned physical address; the sum wraps at 1 MB.
   function automatic logic [19:0] pf_phys_addr(input logic [15:0] ps,
                                                input logic [15:0] pc);
      return {ps, 4'h0} + {4'h0, pc & 16'hFFFE};
   endfunction

endpackage

// File: rtl/prefetch_queue.sv
// rtl/prefetch_queue.sv - byte prefetch queue between bus unit and pre-decoder
//
// Purpose: fetches code words at PS:PC, buffers them in a shifting byte array
// and presents the head bytes and head offset to the decoder. Flush redirects.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   flush, flush_ps, flush_pc     discard queue and redirect fetch
//   suspend                       inhibit new fetch requests
//   fetch_req, fetch_addr         word fetch request / physical address
//   fetch_ack, fetch_data         request accepted, word returned same cycle
//   window, valid_count, head_pc  head bytes, valid byte count, head offset
//   consume, consume_size         decoder pops consume_size bytes

module prefetch_queue
   import prefetch_queue_pkg::*;
#(
   parameter int QUEUE_BYTES  = 8,
   parameter int WINDOW_BYTES = PREFETCH_WINDOW
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      flush,
   input  logic [15:0]               flush_ps,
   input  logic [15:0]               flush_pc,
   input  logic                      suspend,
   output logic                      fetch_req,
   output logic [19:0]               fetch_addr,
   input  logic                      fetch_ack,
   input  logic [15:0]               fetch_data,
   output logic [8*WINDOW_BYTES-1:0] window,
   output logic [3:0]                valid_count,
   output logic [15:0]               head_pc,
   input  logic                      consume,
   input  logic [3:0]                consume_size
);

   localparam int QW = 8 * QUEUE_BYTES;
   localparam int CW = $clog2(QUEUE_BYTES + 1);

   logic [QW-1:0]   store_q, store_d;
   logic [CW-1:0]   count_q, count_d;
   logic [15:0]     head_pc_q, head_pc_d;
   logic [15:0]     fetch_ps_q, fetch_ps_d;
   logic [15:0]     fetch_pc_q, fetch_pc_d;
   logic            discard_low_q, discard_low_d;
   prefetch_state_e state_q;
   logic            fetch_req_q;

   logic            ack_en;
   logic [CW-1:0]   cons_amt;
   logic [CW-1:0]   bytes_in;
   logic [CW-1:0]   survive;
   logic [CW+2:0]   cons_shamt;
   logic [CW+2:0]   surv_shamt;
   logic [15:0]     in_word;
   logic [QW-1:0]   keep_mask;
   logic            issue_ok;
   logic            go_req;

   // Data is only taken while a request is actually outstanding.
   assign ack_en   = fetch_ack && (state_q == PF_REQ);
   assign cons_amt = consume ? CW'(consume_size) : '0;
   assign bytes_in = ack_en ? (discard_low_q ? CW'(1) : CW'(2)) : '0;
   // After a flush to an odd offset, the even byte of the first word is
   // not part of the instruction stream.
   assign in_word  = discard_low_q ? {8'h00, fetch_data[15:8]} : fetch_data;
   assign survive  = count_q - cons_amt;
   assign cons_shamt = {cons_amt, 3'b000};
   assign surv_shamt = {survive, 3'b000};
   assign keep_mask  = (QW'(1) << surv_shamt) - QW'(1);

   always_comb begin
      store_d       = store_q;
      count_d       = count_q;
      head_pc_d     = head_pc_q;
      fetch_ps_d    = fetch_ps_q;
      fetch_pc_d    = fetch_pc_q;
      discard_low_d = discard_low_q;
      if (flush) begin
         // Stale storage is left in place; count=0 makes it invisible.
         count_d       = '0;
         head_pc_d     = flush_pc;
         fetch_pc_d    = flush_pc;
         fetch_ps_d    = flush_ps;
         discard_low_d = flush_pc[0];
      end else begin
         // Pop from the head, then append the new bytes right after the
         // survivors so a consume and an ack can share a cycle.
         store_d = ((store_q >> cons_shamt) & keep_mask)
                 | (ack_en ? (QW'(in_word) << surv_shamt) : '0);
         count_d   = survive + bytes_in;
         head_pc_d = head_pc_q + 16'(cons_amt);
         if (ack_en) begin
            fetch_pc_d    = fetch_pc_q + 16'd2;
            discard_low_d = 1'b0;
         end
      end
   end

   // A request is only issued when a full word is guaranteed to fit.
   assign issue_ok = !suspend && (count_d <= CW'(QUEUE_BYTES - 2));

   always_comb begin
      go_req = 1'b1;
      if (flush || state_q == PF_IDLE || ack_en) begin
         go_req = issue_ok;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= PF_IDLE;
         fetch_req_q <= 1'b0;
      end else begin
         case (state_q)
            PF_IDLE: begin
               if (go_req) begin
                  state_q     <= PF_REQ;
                  fetch_req_q <= 1'b1;
               end
            end
            PF_REQ: begin
               // suspend alone never cancels an issued request; flush does.
               if (flush || ack_en) begin
                  state_q     <= go_req ? PF_REQ : PF_IDLE;
                  fetch_req_q <= go_req;
               end
            end
            default: begin
               state_q     <= PF_IDLE;
               fetch_req_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         store_q       <= '0;
         count_q       <= '0;
         head_pc_q     <= 16'h0000;
         fetch_ps_q    <= PF_RESET_PS;
         fetch_pc_q    <= PF_RESET_PC;
         discard_low_q <= 1'b0;
      end else begin
         store_q       <= store_d;
         count_q       <= count_d;
         head_pc_q     <= head_pc_d;
         fetch_ps_q    <= fetch_ps_d;
         fetch_pc_q    <= fetch_pc_d;
         discard_low_q <= discard_low_d;
      end
   end

   assign fetch_req   = fetch_req_q;
   assign fetch_addr  = pf_phys_addr(fetch_ps_q, fetch_pc_q);
   assign window      = store_q[8*WINDOW_BYTES-1:0];
   assign valid_count = 4'(count_q);
   assign head_pc     = head_pc_q;

   consume_legal_a: assert property (@(posedge clk) disable iff (!reset_n)
      consume |-> (consume_size != 4'd0) &&
                  (int'(consume_size) <= WINDOW_BYTES) &&
                  (int'(consume_size) <= int'(count_q)));

endmodule

// File: tb/tb_prefetch_queue.sv
// tb/tb_prefetch_queue.sv - self-checking bench for prefetch_queue

module tb_prefetch_queue;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush;
   logic [15:0] flush_ps;
   logic [15:0] flush_pc;
   logic        suspend;
   logic        fetch_req;
   logic [19:0] fetch_addr;
   logic        fetch_ack;
   logic [15:0] fetch_data;
   logic [47:0] window;
   logic [3:0]  valid_count;
   logic [15:0] head_pc;
   logic        consume;
   logic [3:0]  consume_size;

   prefetch_queue #(.QUEUE_BYTES(8), .WINDOW_BYTES(6)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .flush        (flush),
      .flush_ps     (flush_ps),
      .flush_pc     (flush_pc),
      .suspend      (suspend),
      .fetch_req    (fetch_req),
      .fetch_addr   (fetch_addr),
      .fetch_ack    (fetch_ack),
      .fetch_data   (fetch_data),
      .window       (window),
      .valid_count  (valid_count),
      .head_pc      (head_pc),
      .consume      (consume),
      .consume_size (consume_size)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Scoreboard of bytes expected at the head of the queue.
   logic [7:0] mq[$];
   bit         mdisc;

   typedef struct {
      bit          ack;
      logic [15:0] data;
      bit          cons;
      logic [3:0]  csz;
      logic [3:0]  vc;
      bit          req;
      logic [15:0] hpc;
      logic [19:0] addr;
   } vec_t;

   vec_t vt[7];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic chk_win(input string nm);
      logic [47:0] e, a;
      e = '0;
      a = '0;
      for (int i = 0; i < 6; i++) begin
         if (i < mq.size()) begin
            e[i*8 +: 8] = mq[i];
            a[i*8 +: 8] = window[i*8 +: 8];
         end
      end
      chk(nm, {16'h0, a}, {16'h0, e});
   endtask

   task automatic chk_out(input string nm, input logic [3:0] vc, input bit req,
                          input logic [15:0] hpc, input logic [19:0] addr);
      chk({nm, ".valid_count"}, {60'h0, valid_count}, {60'h0, vc});
      chk({nm, ".fetch_req"},   {63'h0, fetch_req},   {63'h0, req});
      chk({nm, ".head_pc"},     {48'h0, head_pc},     {48'h0, hpc});
      chk({nm, ".fetch_addr"},  {44'h0, fetch_addr},  {44'h0, addr});
      chk_win({nm, ".window"});
   endtask

   // Drive one cycle of stimulus and record its expected effect on the queue.
   task automatic cyc(input bit a, input logic [15:0] d, input bit c,
                      input logic [3:0] cs, input bit f,
                      input logic [15:0] fps, input logic [15:0] fpc);
      fetch_ack    = a;
      fetch_data   = d;
      consume      = c;
      consume_size = cs;
      flush        = f;
      flush_ps     = fps;
      flush_pc     = fpc;
      if (f) begin
         mq.delete();
         mdisc = fpc[0];
      end else begin
         if (c) repeat (int'(cs)) void'(mq.pop_front());
         if (a) begin
            if (mdisc) mq.push_back(d[15:8]);
            else begin
               mq.push_back(d[7:0]);
               mq.push_back(d[15:8]);
            end
            mdisc = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      fetch_ack = 1'b0;
      consume   = 1'b0;
      flush     = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      flush = 1'b0; flush_ps = '0; flush_pc = '0; suspend = 1'b0;
      fetch_ack = 1'b0; fetch_data = '0; consume = 1'b0; consume_size = 4'd1;
      mdisc = 1'b0;

      //        ack  data      cons csz  vc  req hpc      addr
      vt[0] = '{1, 16'h7856, 0, 4'd0, 4'd4, 1, 16'h0000, 20'hFFFF4};
      vt[1] = '{1, 16'hBC9A, 0, 4'd0, 4'd6, 1, 16'h0000, 20'hFFFF6};
      vt[2] = '{1, 16'hF0DE, 0, 4'd0, 4'd8, 0, 16'h0000, 20'hFFFF8};
      vt[3] = '{0, 16'h0000, 0, 4'd0, 4'd8, 0, 16'h0000, 20'hFFFF8};
      vt[4] = '{0, 16'h0000, 1, 4'd3, 4'd5, 1, 16'h0003, 20'hFFFF8};
      vt[5] = '{0, 16'h0000, 1, 4'd1, 4'd4, 1, 16'h0004, 20'hFFFF8};
      vt[6] = '{1, 16'h3322, 1, 4'd2, 4'd4, 1, 16'h0006, 20'hFFFFA};

      repeat (2) @(posedge clk);
      #1;
      chk_out("reset", 4'd0, 0, 16'h0000, 20'hFFFF0);
      chk("reset.window_raw", {16'h0, window}, 64'h0);
      reset_n = 1'b1;

      cyc(0, 16'h0, 0, 4'd0, 0, 16'h0, 16'h0);
      chk_out("first_req", 4'd0, 1, 16'h0000, 20'hFFFF0);

      cyc(1, 16'h3412, 0, 4'd0, 0, 16'h0, 16'h0);
      chk_out("ack_3412", 4'd2, 1, 16'h0000, 20'hFFFF2);
      chk("ack_3412.window16", {48'h0, window[15:0]}, 64'h3412);

      foreach (vt[i]) begin
         cyc(vt[i].ack, vt[i].data, vt[i].cons, vt[i].csz, 0, 16'h0, 16'h0);
         chk_out($sformatf("vec%0d", i), vt[i].vc, vt[i].req, vt[i].hpc, vt[i].addr);
      end
      chk("merge.window32", {32'h0, window[31:0]}, 64'h3322F0DE);

      // Flush while a request is outstanding; odd target drops the low byte.
      cyc(0, 16'h0, 0, 4'd0, 1, 16'h1000, 16'h0005);
      chk_out("flush1", 4'd0, 1, 16'h0005, 20'h10004);
      cyc(1, 16'hBBAA, 0, 4'd0, 0, 16'h0, 16'h0);
      chk_out("flush1_ack", 4'd1, 1, 16'h0005, 20'h10006);
      chk("flush1_ack.byte0", {56'h0, window[7:0]}, 64'hBB);
      cyc(1, 16'hDDCC, 0, 4'd0, 0, 16'h0, 16'h0);
      chk_out("flush1_ack2", 4'd3, 1, 16'h0005, 20'h10008);

      // Flush wins over a same-cycle ack and consume.
      cyc(1, 16'h1111, 1, 4'd2, 1, 16'h2000, 16'hFFFE);
      chk_out("flush2", 4'd0, 1, 16'hFFFE, 20'h2FFFE);
      cyc(1, 16'h4433, 0, 4'd0, 0, 16'h0, 16'h0);
      chk_out("wrap_ack", 4'd2, 1, 16'hFFFE, 20'h20000);
      cyc(0, 16'h0, 1, 4'd2, 0, 16'h0, 16'h0);
      chk_out("head_wrap", 4'd0, 1, 16'h0000, 20'h20000);

      // Suspend holds off new requests but not the one already issued.
      suspend = 1'b1;
      cyc(0, 16'h0, 0, 4'd0, 0, 16'h0, 16'h0);
      chk_out("susp_hold", 4'd0, 1, 16'h0000, 20'h20000);
      cyc(1, 16'h6655, 0, 4'd0, 0, 16'h0, 16'h0);
      chk_out("susp_ack", 4'd2, 0, 16'h0000, 20'h20002);
      suspend = 1'b0;
      cyc(0, 16'h0, 0, 4'd0, 0, 16'h0, 16'h0);
      chk_out("susp_release", 4'd2, 1, 16'h0000, 20'h20002);

      // Asynchronous reset in the middle of a request.
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      mq.delete();
      mdisc = 1'b0;
      #1;
      chk_out("async_rst", 4'd0, 0, 16'h0000, 20'hFFFF0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cyc(0, 16'h0, 0, 4'd0, 0, 16'h0, 16'h0);
      chk_out("post_rst", 4'd0, 1, 16'h0000, 20'hFFFF0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
